// File: rtl/color_pkg.sv
// Shared types for the colour vote filter: colour encoding, FSM states and
// the colour-to-step mapping used by the game FSM.
package color_pkg;

  localparam int NUM_COLORS = 4;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    BLUE  = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    DECIDE = 2'd2
  } vote_state_t;

  function automatic logic [1:0] color_to_steps(input color_t c);
    logic [1:0] steps;
    case (c)
      RED:     steps = 2'd1;
      GREEN:   steps = 2'd2;
      BLUE:    steps = 2'd3;
      default: steps = 2'd0;
    endcase
    return steps;
  endfunction

endpackage

// File: rtl/color_history_ring.sv
// Ring buffer of the last WINDOW frame results with a write pointer, a
// saturating fill count and a combinational read port addressed by index.
module color_history_ring
  import color_pkg::*;
#(
  parameter int WINDOW = 5,
  parameter int CONF_W = 16,
  parameter int PTR_W  = $clog2(WINDOW)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  color_t            wr_color,
  input  logic [CONF_W-1:0] wr_conf,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic              rd_valid,
  output color_t            rd_color,
  output logic [CONF_W-1:0] rd_conf,
  output logic [3:0]        fill_count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WINDOW - 1);
  localparam logic [3:0]       FULL     = 4'(WINDOW);

  logic [WINDOW-1:0] valid_q, valid_d;
  color_t            color_q [WINDOW];
  color_t            color_d [WINDOW];
  logic [CONF_W-1:0] conf_q  [WINDOW];
  logic [CONF_W-1:0] conf_d  [WINDOW];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]        fill_q, fill_d;

  always_comb begin
    valid_d  = valid_q;
    color_d  = color_q;
    conf_d   = conf_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    // Flushing only the valid bits is enough: stale payload is never counted.
    if (clear) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (wr_en) begin
      valid_d[wr_ptr_q] = 1'b1;
      color_d[wr_ptr_q] = wr_color;
      conf_d[wr_ptr_q]  = wr_conf;
      wr_ptr_d          = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (fill_q != FULL) fill_d = fill_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      for (int i = 0; i < WINDOW; i++) begin
        color_q[i] <= NONE;
        conf_q[i]  <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      color_q  <= color_d;
      conf_q   <= conf_d;
    end
  end

  assign rd_valid   = valid_q[rd_idx];
  assign rd_color   = color_q[rd_idx];
  assign rd_conf    = conf_q[rd_idx];
  assign fill_count = fill_q;

endmodule

// File: rtl/color_vote_filter.sv
// Temporal majority-vote filter over the last WINDOW colour detections, with
// a hold/timeout rule when no colour wins. One decision per accepted frame.
module color_vote_filter
  import color_pkg::*;
#(
  parameter int WINDOW         = 5,
  parameter int MAJORITY       = (WINDOW / 2) + 1,
  parameter int CONF_W         = 16,
  parameter int MIN_CONFIDENCE = 100,
  parameter int HOLD_FRAMES    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  color_t            in_color,
  input  logic              in_valid,
  input  logic [CONF_W-1:0] in_conf,
  input  logic              clear,
  output color_t            out_color,
  output logic [1:0]        out_steps,
  output logic [CONF_W-1:0] out_conf,
  output logic              out_valid,
  output logic              out_changed,
  output logic              locked,
  output logic [3:0]        fill_count,
  output logic              overrun,
  output vote_state_t       dbg_state
);

  // Handshake: in_valid is a one-cycle pulse accepted only in IDLE; frames
  // arriving in COUNT/DECIDE are dropped and flagged on overrun. out_valid is
  // a one-cycle pulse with no backpressure, WINDOW+2 cycles after acceptance.

  localparam int                PTR_W    = $clog2(WINDOW);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(WINDOW - 1);
  localparam logic [3:0]        MAJ      = 4'(MAJORITY);
  localparam logic [3:0]        HOLD_MAX = 4'(HOLD_FRAMES);
  localparam logic [CONF_W-1:0] MIN_CONF = CONF_W'(MIN_CONFIDENCE);

  vote_state_t       state_q, state_d;
  logic [PTR_W-1:0]  scan_q, scan_d;
  logic [3:0]        votes_q [NUM_COLORS];
  logic [3:0]        votes_d [NUM_COLORS];
  logic [CONF_W-1:0] maxc_q  [NUM_COLORS];
  logic [CONF_W-1:0] maxc_d  [NUM_COLORS];
  color_t            out_color_q, out_color_d;
  logic [CONF_W-1:0] out_conf_q, out_conf_d;
  logic              locked_q, locked_d;
  logic [3:0]        hold_q, hold_d;
  logic              out_valid_q, out_valid_d;
  logic              out_changed_q, out_changed_d;
  logic              overrun_q, overrun_d;

  logic              wr_en;
  color_t            wr_color;
  logic [CONF_W-1:0] wr_conf;
  logic              rd_valid;
  color_t            rd_color;
  logic [CONF_W-1:0] rd_conf;
  color_t            winner;
  logic              win_found;

  // Low-confidence frames still occupy a slot, as a NONE vote.
  assign wr_en    = in_valid && (state_q == IDLE) && !clear;
  assign wr_color = (in_conf >= MIN_CONF) ? in_color : NONE;
  assign wr_conf  = (in_conf >= MIN_CONF) ? in_conf : '0;

  color_history_ring #(
    .WINDOW (WINDOW),
    .CONF_W (CONF_W),
    .PTR_W  (PTR_W)
  ) u_ring (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_color   (wr_color),
    .wr_conf    (wr_conf),
    .rd_idx     (scan_q),
    .rd_valid   (rd_valid),
    .rd_color   (rd_color),
    .rd_conf    (rd_conf),
    .fill_count (fill_count)
  );

  always_comb begin
    winner    = NONE;
    win_found = 1'b0;
    for (int c = 1; c < NUM_COLORS; c++) begin
      if (votes_q[c] >= MAJ) begin
        winner    = color_t'(c[1:0]);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    scan_d        = scan_q;
    votes_d       = votes_q;
    maxc_d        = maxc_q;
    out_color_d   = out_color_q;
    out_conf_d    = out_conf_q;
    locked_d      = locked_q;
    hold_d        = hold_q;
    out_valid_d   = 1'b0;
    out_changed_d = 1'b0;
    overrun_d     = overrun_q;
    if (clear) begin
      state_d     = IDLE;
      scan_d      = '0;
      out_color_d = NONE;
      out_conf_d  = '0;
      locked_d    = 1'b0;
      hold_d      = '0;
      overrun_d   = 1'b0;
    end else begin
      if (in_valid && (state_q != IDLE)) overrun_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d = COUNT;
            scan_d  = '0;
            for (int c = 0; c < NUM_COLORS; c++) begin
              votes_d[c] = '0;
              maxc_d[c]  = '0;
            end
          end
        end
        COUNT: begin
          if (rd_valid) begin
            votes_d[rd_color] = votes_q[rd_color] + 4'd1;
            if (rd_conf > maxc_q[rd_color]) maxc_d[rd_color] = rd_conf;
          end
          if (scan_q == LAST_IDX) state_d = DECIDE;
          else                    scan_d  = scan_q + 1'b1;
        end
        DECIDE: begin
          out_valid_d = 1'b1;
          locked_d    = 1'b0;
          if (win_found) begin
            out_color_d = winner;
            out_conf_d  = maxc_q[winner];
            locked_d    = 1'b1;
            hold_d      = '0;
          end else if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + 4'd1;
          end else begin
            out_color_d = NONE;
            out_conf_d  = '0;
          end
          out_changed_d = (out_color_d != out_color_q);
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      scan_q        <= '0;
      out_color_q   <= NONE;
      out_conf_q    <= '0;
      locked_q      <= 1'b0;
      hold_q        <= '0;
      out_valid_q   <= 1'b0;
      out_changed_q <= 1'b0;
      overrun_q     <= 1'b0;
      for (int c = 0; c < NUM_COLORS; c++) begin
        votes_q[c] <= '0;
        maxc_q[c]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      scan_q        <= scan_d;
      out_color_q   <= out_color_d;
      out_conf_q    <= out_conf_d;
      locked_q      <= locked_d;
      hold_q        <= hold_d;
      out_valid_q   <= out_valid_d;
      out_changed_q <= out_changed_d;
      overrun_q     <= overrun_d;
      votes_q       <= votes_d;
      maxc_q        <= maxc_d;
    end
  end

  assign out_color   = out_color_q;
  assign out_steps   = color_to_steps(out_color_q);
  assign out_conf    = out_conf_q;
  assign out_valid   = out_valid_q;
  assign out_changed = out_changed_q;
  assign locked      = locked_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_color_vote_filter.sv
// Bench for color_vote_filter (WINDOW=5, MAJORITY=3, HOLD_FRAMES=2): directed
// scenarios plus random frames against a sliding-window recount model.
module tb_color_vote_filter;
  import color_pkg::*;

  localparam int LAT = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  color_t      in_color = NONE;
  logic        in_valid = 1'b0;
  logic [15:0] in_conf = '0;
  logic        clear = 1'b0;
  color_t      out_color;
  logic [1:0]  out_steps;
  logic [15:0] out_conf;
  logic        out_valid;
  logic        out_changed;
  logic        locked;
  logic [3:0]  fill_count;
  logic        overrun;
  vote_state_t dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Expected decision: {color, steps, conf, locked, changed, fill, overrun}
  logic [26:0] exp_q[$];
  logic [1:0]  hist_c[$];
  logic [15:0] hist_f[$];
  logic [1:0]  m_color;
  logic [15:0] m_conf;
  logic        m_locked;
  int          m_hold;
  logic        m_overrun;

  color_vote_filter #(
    .WINDOW(5), .MAJORITY(3), .CONF_W(16), .MIN_CONFIDENCE(100), .HOLD_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .in_color(in_color), .in_valid(in_valid),
    .in_conf(in_conf), .clear(clear), .out_color(out_color), .out_steps(out_steps),
    .out_conf(out_conf), .out_valid(out_valid), .out_changed(out_changed),
    .locked(locked), .fill_count(fill_count), .overrun(overrun), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    hist_c.delete();
    hist_f.delete();
    exp_q.delete();
    m_color = 2'd0; m_conf = '0; m_locked = 1'b0; m_hold = 0; m_overrun = 1'b0;
  endtask

  task automatic model_frame(input logic [1:0] c, input logic [15:0] conf);
    int          votes[4];
    logic [15:0] mx[4];
    int          win;
    logic [1:0]  prev;
    logic [1:0]  steps_tbl[4];
    steps_tbl[0] = 2'd0; steps_tbl[1] = 2'd1; steps_tbl[2] = 2'd2; steps_tbl[3] = 2'd3;
    if (conf >= 16'd100) begin
      hist_c.push_back(c); hist_f.push_back(conf);
    end else begin
      hist_c.push_back(2'd0); hist_f.push_back(16'd0);
    end
    if (hist_c.size() > 5) begin
      void'(hist_c.pop_front());
      void'(hist_f.pop_front());
    end
    for (int k = 0; k < 4; k++) begin votes[k] = 0; mx[k] = '0; end
    foreach (hist_c[i]) begin
      votes[hist_c[i]]++;
      if (hist_f[i] > mx[hist_c[i]]) mx[hist_c[i]] = hist_f[i];
    end
    win = 0;
    for (int k = 1; k < 4; k++) if (votes[k] >= 3) win = k;
    prev = m_color;
    if (win != 0) begin
      m_color = 2'(win); m_conf = mx[win]; m_locked = 1'b1; m_hold = 0;
    end else if (m_hold < 2) begin
      m_hold++; m_locked = 1'b0;
    end else begin
      m_color = 2'd0; m_conf = '0; m_locked = 1'b0;
    end
    exp_q.push_back({m_color, steps_tbl[m_color], m_conf, m_locked, (m_color != prev),
                     4'(hist_c.size()), m_overrun});
  endtask

  // ---------------- drivers ----------------
  task automatic drive_frame(input logic [1:0] c, input logic [15:0] conf,
                             output logic [26:0] obs, output int lat);
    @(negedge clk);
    in_color = color_t'(c); in_conf = conf; in_valid = 1'b1;
    lat = 0; obs = '0;
    while (lat < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) begin
        obs = {out_color, out_steps, out_conf, locked, out_changed, fill_count, overrun};
        break;
      end
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_color, out_steps, out_conf, out_valid, out_changed, locked, fill_count, overrun} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got color=%0d steps=%0d conf=%0d valid=%0b chg=%0b lock=%0b fill=%0d ovr=%0b expected all 0",
               out_color, out_steps, out_conf, out_valid, out_changed, locked, fill_count, overrun);
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    reset = 1'b0;
  endtask

  task automatic test_lock_red();
    logic [26:0] obs; int lat;
    for (int i = 0; i < 3; i++) begin
      model_frame(2'd1, 16'd200);
      drive_frame(2'd1, 16'd200, obs, lat);
      n_cmp++;
      if (lat !== LAT) begin n_err++; $display("FAIL lock_red_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
      n_cmp++;
      if (obs !== exp_q[0]) begin n_err++; $display("FAIL lock_red[%0d]: got %h expected %h", i, obs, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL lock_red_pulse_width: got %0b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_color = RED; in_conf = 16'd200; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_color, out_conf, out_valid, locked, fill_count, overrun} !== '0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_async: got color=%0d conf=%0d lock=%0b fill=%0d ovr=%0b state=%0d expected 0",
               out_color, out_conf, locked, fill_count, overrun, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_pulse[%0d]: got %0b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_majority_switch();
    logic [1:0]  cols[6];
    logic [15:0] confs[6];
    logic [26:0] obs; int lat;
    cols  = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    confs = '{16'd200, 16'd210, 16'd190, 16'd150, 16'd180, 16'd170};
    do_clear();
    for (int i = 0; i < 6; i++) begin
      model_frame(cols[i], confs[i]);
      drive_frame(cols[i], confs[i], obs, lat);
      n_cmp++;
      if (lat !== LAT) begin n_err++; $display("FAIL switch_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
      n_cmp++;
      if (obs !== exp_q[0]) begin n_err++; $display("FAIL switch[%0d]: got %h expected %h", i, obs, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_hold_timeout();
    logic [1:0]  cols[8];
    logic [26:0] obs; int lat;
    cols = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd2};
    do_clear();
    for (int i = 0; i < 8; i++) begin
      model_frame(cols[i], 16'd200 + 16'(i));
      drive_frame(cols[i], 16'd200 + 16'(i), obs, lat);
      n_cmp++;
      if (obs !== exp_q[0]) begin n_err++; $display("FAIL hold[%0d]: got %h expected %h", i, obs, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_low_conf();
    logic [26:0] obs; int lat;
    do_clear();
    for (int i = 0; i < 8; i++) begin
      // Five frames one below threshold, then three exactly at threshold.
      model_frame(2'd3, (i < 5) ? 16'd99 : 16'd100);
      drive_frame(2'd3, (i < 5) ? 16'd99 : 16'd100, obs, lat);
      n_cmp++;
      if (obs !== exp_q[0]) begin n_err++; $display("FAIL low_conf[%0d]: got %h expected %h", i, obs, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_overrun();
    logic [26:0] obs; int lat; int first_lat; int pulses;
    do_clear();
    m_overrun = 1'b1;
    model_frame(2'd3, 16'd150);
    @(negedge clk);
    in_color = BLUE; in_conf = 16'd150; in_valid = 1'b1;
    lat = 0; pulses = 0; first_lat = -1; obs = '0;
    while (lat < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (lat == 3) begin in_color = GREEN; in_conf = 16'd300; in_valid = 1'b1; end
      if (out_valid) begin
        pulses++;
        if (first_lat < 0) begin
          first_lat = lat;
          obs = {out_color, out_steps, out_conf, locked, out_changed, fill_count, overrun};
        end
      end
    end
    n_cmp++;
    if (pulses !== 1) begin n_err++; $display("FAIL overrun_pulses: got %0d expected 1", pulses); end
    n_cmp++;
    if (first_lat !== LAT) begin n_err++; $display("FAIL overrun_latency: got %0d expected %0d", first_lat, LAT); end
    n_cmp++;
    if (obs !== exp_q[0]) begin n_err++; $display("FAIL overrun_decision: got %h expected %h", obs, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_clear_mid_count();
    logic [26:0] obs; int lat;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      model_frame(2'd1, 16'd220);
      drive_frame(2'd1, 16'd220, obs, lat);
      void'(exp_q.pop_front());
    end
    n_cmp++;
    if (locked !== 1'b1 || out_color !== RED) begin
      n_err++; $display("FAIL clear_prelock: got color=%0d lock=%0b expected color=1 lock=1", out_color, locked);
    end
    @(negedge clk);
    in_color = RED; in_conf = 16'd220; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_cmp++;
    if ({out_color, out_steps, out_conf, locked, fill_count, overrun} !== '0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL clear_state: got color=%0d conf=%0d lock=%0b fill=%0d ovr=%0b state=%0d expected 0",
               out_color, out_conf, locked, fill_count, overrun, dbg_state);
    end
    model_reset();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_no_pulse[%0d]: got %0b expected 0", i, out_valid); end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      model_frame(2'd1, 16'd200);
      drive_frame(2'd1, 16'd200, obs, lat);
      n_cmp++;
      if (obs !== exp_q[0]) begin n_err++; $display("FAIL clear_relock[%0d]: got %h expected %h", i, obs, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_random();
    logic [26:0] obs; int lat;
    logic [1:0]  c;
    logic [15:0] conf;
    do_clear();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 14) == 0) do_clear();
      // Bias toward one colour so locks and hold timeouts both occur.
      c    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      conf = 16'($urandom_range(90, 260));
      model_frame(c, conf);
      drive_frame(c, conf, obs, lat);
      n_cmp++;
      if (lat !== LAT) begin n_err++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
      n_cmp++;
      if (obs !== exp_q[0]) begin n_err++; $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_q[0]); end
      void'(exp_q.pop_front());
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_lock_red();
    test_reset_mid();
    test_majority_switch();
    test_hold_timeout();
    test_low_conf();
    test_overrun();
    test_clear_mid_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
